// File: rtl/riscv_dmem_mmio_if.sv
// CPU data-side bus: store strobe, byte address, store data and combinational load data.
interface riscv_dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output Mem_WrAddr, output Mem_WrData, input ReadData);
    modport slave  (input MemWrite, input Mem_WrAddr, input Mem_WrData, output ReadData);
endinterface

// File: rtl/riscv_dmem_mmio.sv
// Data RAM plus MMIO page (GPIO, cycle counter, byte TX FIFO) answering the CPU data bus.
module riscv_dmem_mmio #(
    parameter int          RAM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          GPIO_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_dmem_mmio_if.slave     bus,
    input  logic [GPIO_W-1:0]    gpio_in,
    output logic [GPIO_W-1:0]    gpio_out,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    logic [31:0]       ram_mem  [RAM_WORDS];
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       cycle_q, cycle_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       addr, wdata, rdata;
    logic [7:0]        off;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_hit, mmio_hit;
    logic              wr_gpio, wr_cycle, wr_tx, wr_status;
    logic              fifo_full, fifo_empty, pop, push_ok;

    assign addr     = bus.Mem_WrAddr;
    assign wdata    = bus.Mem_WrData;
    assign off      = addr[7:0];
    assign ram_idx  = addr[IDX_W+1:2];
    assign ram_hit  = addr < RAM_BYTES;
    assign mmio_hit = addr[31:8] == MMIO_BASE[31:8];

    assign wr_gpio   = bus.MemWrite & mmio_hit & (off == 8'h00);
    assign wr_cycle  = bus.MemWrite & mmio_hit & (off == 8'h08);
    assign wr_tx     = bus.MemWrite & mmio_hit & (off == 8'h0C);
    assign wr_status = bus.MemWrite & mmio_hit & (off == 8'h10);

    assign fifo_full  = count_q == DEPTH_C;
    assign fifo_empty = count_q == '0;
    assign pop        = ~fifo_empty & tx_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
    assign push_ok    = wr_tx & (~fifo_full | pop);

    always_comb begin
        gpio_out_d = gpio_out_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        cycle_d    = wr_cycle ? wdata : cycle_q + 32'd1;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        if (wr_gpio) gpio_out_d = wdata[GPIO_W-1:0];
        if (pop)     rd_ptr_d   = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d   = wr_ptr_q + 1'b1;
        if (wr_tx & ~push_ok)           ovf_d = 1'b1;
        else if (wr_status & wdata[2])  ovf_d = 1'b0;
    end

    // Storage arrays carry no reset; FIFO emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (bus.MemWrite & ram_hit) ram_mem[ram_idx]   <= wdata;
        if (push_ok)                fifo_mem[wr_ptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cycle_q    <= cycle_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (ram_hit) begin
            rdata = ram_mem[ram_idx];
        end else if (mmio_hit) begin
            case (off)
                8'h00:   rdata = 32'(gpio_out_q);
                8'h04:   rdata = 32'(sync2_q);
                8'h08:   rdata = cycle_q;
                8'h10:   rdata = {23'h0, 5'(count_q), 1'b0, ovf_q, fifo_empty, fifo_full};
                default: rdata = 32'h0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign gpio_out     = gpio_out_q;
    assign tx_valid     = ~fifo_empty;
    assign tx_data      = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Directed bench for riscv_dmem_mmio: behavioural model compared every cycle plus literal spot checks.
module tb_riscv_dmem_mmio;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPO = BASE + 32'h00;
    localparam logic [31:0] A_GPI = BASE + 32'h04;
    localparam logic [31:0] A_CYC = BASE + 32'h08;
    localparam logic [31:0] A_TXD = BASE + 32'h0C;
    localparam logic [31:0] A_STS = BASE + 32'h10;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio_in, gpio_out, tx_data;
    logic       tx_valid, tx_ready;

    riscv_dmem_mmio_if bus ();

    riscv_dmem_mmio #(
        .RAM_WORDS (64),
        .MMIO_BASE (BASE),
        .FIFO_DEPTH(DEPTH),
        .GPIO_W    (8)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (bus),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Model state: plain arrays, a byte queue and integer counters.
    logic [31:0] m_ram [64];
    bit          m_known [64];
    logic [7:0]  m_gpo;
    logic [7:0]  m_pin_last, m_pin_older;
    int unsigned m_cyc;
    logic [7:0]  m_q [$];
    bit          m_ovf;

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        int unsigned ua;
        ua    = a;
        known = 1'b1;
        if (ua < 256) begin
            known = m_known[ua / 4];
            return m_ram[ua / 4];
        end
        if ((a & 32'hFFFF_FF00) != BASE) return 32'h0;
        case (a - BASE)
            32'h00: return {24'h0, m_gpo};
            32'h04: return {24'h0, m_pin_older};
            32'h08: return m_cyc;
            32'h10: return (m_q.size() << 4) | (m_ovf ? 4 : 0)
                           | (m_q.size() == 0 ? 2 : 0) | (m_q.size() == DEPTH ? 1 : 0);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        bit do_pop, do_push, room;
        int unsigned ua;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_gpo = 0; m_pin_last = 0; m_pin_older = 0;
                m_cyc = 0; m_q.delete(); m_ovf = 0;
            end else begin
                ua      = bus.Mem_WrAddr;
                do_pop  = (m_q.size() != 0) && tx_ready;
                do_push = bus.MemWrite && bus.Mem_WrAddr == A_TXD;
                room    = (m_q.size() < DEPTH) || do_pop;
                if (do_push && !room) m_ovf = 1;
                if (bus.MemWrite && bus.Mem_WrAddr == A_STS && bus.Mem_WrData[2]) m_ovf = 0;
                if (do_pop) void'(m_q.pop_front());
                if (do_push && room) m_q.push_back(bus.Mem_WrData[7:0]);
                if (bus.MemWrite && ua < 256) begin
                    m_ram[ua / 4]   = bus.Mem_WrData;
                    m_known[ua / 4] = 1;
                end
                if (bus.MemWrite && bus.Mem_WrAddr == A_GPO) m_gpo = bus.Mem_WrData[7:0];
                if (bus.MemWrite && bus.Mem_WrAddr == A_CYC) m_cyc = bus.Mem_WrData;
                else m_cyc = m_cyc + 1;
                m_pin_older = m_pin_last;
                m_pin_last  = gpio_in;
            end
        end
    end

    initial begin
        logic [31:0] exp;
        bit known;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_tx_valid", {31'h0, tx_valid}, (m_q.size() != 0) ? 1 : 0);
                check("cyc_tx_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
                check("cyc_gpio_out", {24'h0, gpio_out}, {24'h0, m_gpo});
                exp = model_read(bus.Mem_WrAddr, known);
                if (known) check("cyc_ReadData", bus.ReadData, exp);
            end
        end
    end

    task automatic setbus(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        bus.MemWrite   = we;
        bus.Mem_WrAddr = a;
        bus.Mem_WrData = d;
    endtask

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
        bus.MemWrite = 0; bus.Mem_WrAddr = 0; bus.Mem_WrData = 0;
        gpio_in = 0; tx_ready = 0;

        repeat (3) @(posedge clk);
        #2 rst_n = 1; bus.Mem_WrAddr = A_CYC;
        #1;
        check("rst_cycle", bus.ReadData, 32'h0);
        check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        repeat (10) @(posedge clk);
        #2 check("cycle_10", bus.ReadData, 32'd10);

        setbus(1, A_CYC, 32'hFFFF_FFFE);
        setbus(0, A_CYC, 0); #1 check("cycle_load", bus.ReadData, 32'hFFFF_FFFE);
        setbus(0, A_CYC, 0); #1 check("cycle_max", bus.ReadData, 32'hFFFF_FFFF);
        setbus(0, A_CYC, 0); #1 check("cycle_wrap", bus.ReadData, 32'h0);

        setbus(1, 32'h10, 32'hDEAD_BEEF);
        setbus(0, 32'h10, 0); #1 check("ram_0x10", bus.ReadData, 32'hDEAD_BEEF);
        setbus(0, 32'h12, 0); #1 check("ram_0x12", bus.ReadData, 32'hDEAD_BEEF);
        setbus(1, 32'h0, 32'h1111_1111);
        setbus(1, 32'h100, 32'h2222_2222);
        setbus(1, 32'hFC, 32'h3333_3333);
        setbus(0, 32'h0, 0);   #1 check("ram_0x00", bus.ReadData, 32'h1111_1111);
        setbus(0, 32'h100, 0); #1 check("unmapped_0x100", bus.ReadData, 32'h0);
        setbus(0, 32'hFC, 0);  #1 check("ram_0xFC", bus.ReadData, 32'h3333_3333);

        setbus(1, A_GPO, 32'h1A5);
        setbus(0, A_GPI, 0); gpio_in = 8'h3C;
        #1 check("gpio_out", {24'h0, gpio_out}, 32'hA5);
        check("gpio_in_0edge", bus.ReadData, 32'h0);
        setbus(0, A_GPI, 0); #1 check("gpio_in_1edge", bus.ReadData, 32'h0);
        setbus(0, A_GPI, 0); #1 check("gpio_in_2edge", bus.ReadData, 32'h3C);
        setbus(0, A_GPO, 0); #1 check("gpio_out_rd", bus.ReadData, 32'hA5);

        for (int i = 0; i < 8; i++) setbus(1, A_TXD, 32'h41 + i);
        setbus(0, A_STS, 0);
        #1 check("sts_full", bus.ReadData, 32'h81);
        check("head_0x41", {24'h0, tx_data}, 32'h41);
        setbus(1, A_TXD, 32'h49);
        setbus(0, A_STS, 0); #1 check("sts_overflow", bus.ReadData, 32'h85);
        setbus(1, A_STS, 32'h4);
        setbus(0, A_STS, 0); #1 check("sts_ovf_clr", bus.ReadData, 32'h81);

        setbus(1, A_TXD, 32'h50); tx_ready = 1;
        setbus(0, A_STS, 0); tx_ready = 0;
        #1 check("sts_push_pop", bus.ReadData, 32'h81);
        check("head_0x42", {24'h0, tx_data}, 32'h42);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("drain", {24'h0, tx_data}, {24'h0, drain_exp[i]});
            @(posedge clk);
            #3;
        end
        tx_ready = 0;
        check("sts_drained", bus.ReadData, 32'h02);
        check("drained_valid", {31'h0, tx_valid}, 32'h0);

        setbus(1, A_TXD, 32'h55);
        #1 check("push_latency", {31'h0, tx_valid}, 32'h0);
        setbus(0, A_STS, 0);
        #1 check("push_visible", {24'h0, tx_data}, 32'h55);
        check("sts_one", bus.ReadData, 32'h10);
        rst_n = 0;
        #1;
        check("midrst_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_data", {24'h0, tx_data}, 32'h0);
        check("midrst_sts", bus.ReadData, 32'h02);
        check("midrst_gpio", {24'h0, gpio_out}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1;

        setbus(0, 32'h8000_0000, 0); #1 check("unmapped_8000", bus.ReadData, 32'h0);
        setbus(0, BASE + 32'h14, 0); #1 check("mmio_hole", bus.ReadData, 32'h0);
        setbus(0, A_TXD, 0);         #1 check("txdata_rd0", bus.ReadData, 32'h0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_mmio.md
Name: riscv_dmem_mmio

Overview:
- Data-side responder for the single-cycle CPU's memory bus: it answers the `MemWrite` / `Mem_WrAddr` / `Mem_WrData` / `ReadData` interface.
- Contains a word-addressed data RAM and a small MMIO page: GPIO out/in, a free-running cycle counter, and a byte TX FIFO drained over a valid/ready stream.
- Sits beside the CPU in the top-level SoC, replacing the bare data memory.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words (power of 2).
- MMIO_BASE, 32'hFFFF_0000, base of the 256-byte MMIO page.
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..16).
- GPIO_W, 8, GPIO width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- MemWrite  in  1  store strobe from CPU.
- Mem_WrAddr  in  32  load/store byte address (ALU result).
- Mem_WrData  in  32  store data.
- ReadData  out  32  load data, combinational from address.
- gpio_in  in  GPIO_W  external inputs, asynchronous.
- gpio_out  out  GPIO_W  registered outputs.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head this cycle.

Behaviour:
- Decode:
  - RAM hit when Mem_WrAddr < RAM_WORDS*4; index = addr[log2(RAM_WORDS)+1:2]. addr[1:0] ignored, word access only.
  - MMIO hit when addr[31:8] == MMIO_BASE[31:8]; offset = addr[7:0].
  - Anything else unmapped: reads 0, writes ignored.
- Reads: purely combinational, no side effects; ReadData valid in the same cycle as the address.
- Writes: take effect at the rising edge where MemWrite=1.
- RAM is not reset; its contents are X until written.
- MMIO map (unlisted offsets read 0, writes ignored):
  - 0x00 GPIO_OUT, RW: gpio_out = Mem_WrData[GPIO_W-1:0].
  - 0x04 GPIO_IN, RO: gpio_in through a 2-flop synchroniser, zero-extended. Reflects a pin change 2 edges later.
  - 0x08 CYCLE, RW: increments by 1 every cycle and wraps 0xFFFFFFFF -> 0. A write loads Mem_WrData with no increment that edge, so the next cycle reads the written value.
  - 0x0C TX_DATA, WO: a write pushes Mem_WrData[7:0]; reads 0.
  - 0x10 TX_STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count (0..FIFO_DEPTH), rest 0. Writing 1 to bit2 clears overflow; other bits are RO.
- TX FIFO:
  - Circular buffer with rd/wr pointers plus count.
  - tx_valid = (count != 0); tx_data = head entry, or 8'h00 when empty.
  - Pop on an edge with tx_valid & tx_ready.
  - Push accepted if count < FIFO_DEPTH, or if a pop occurs the same edge (full + push + pop leaves count unchanged).
  - Push with full and no pop: byte dropped, overflow set to 1.
  - Push with empty: byte appears on tx_data/tx_valid the next cycle (1-cycle latency). No same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push + overflow-clear in the same cycle cannot collide (different offsets).
- Reset (asynchronous assert, synchronous to clk on release):
  - gpio_out=0, sync flops=0, CYCLE=0.
  - FIFO empty with pointers 0, so tx_valid=0 and tx_data=0.
  - overflow=0.
  - ReadData follows decode (RAM X, MMIO per reset state).
  - Reset mid-stream discards FIFO contents immediately.

Test Plan:
- Reset, then write RAM addr 0x10 = 0xDEADBEEF; next cycle read addr 0x10 -> ReadData=0xDEADBEEF, and addr 0x12 also returns 0xDEADBEEF.
- Write GPIO_OUT 0x1A5 (GPIO_W=8) -> gpio_out=0xA5 after edge. Drive gpio_in=0x3C -> GPIO_IN reads 0x3C from the 2nd edge on, 0 before.
- Let CYCLE run 10 cycles after reset -> reads 10. Write 0xFFFFFFFE -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000.
- tx_ready=0; push 0x41..0x48 (8 bytes) -> STATUS count=8, full=1. Push 0x49 -> dropped, overflow=1. Write STATUS 0x4 -> overflow=0.
- FIFO full with tx_ready=1 and a push of 0x50 in the same cycle -> 0x41 popped, 0x50 accepted, count stays 8. Drain order 0x42..0x48, 0x50.
- Push 0x55 then assert reset mid-stream -> tx_valid=0, tx_data=0, count=0 immediately. Unmapped addr 0x8000_0000 reads 0.
